// File: rtl/magnetron_logic_if.sv
// magnetron_logic_if: operator/door/timer inputs and latch command outputs of the magnetron control core
//   start_, stop_, clear_  active-low operator buttons (asynchronous to clk)
//   door_closed            1 = door closed
//   timer_done             1 = cook timer expired
//   S, R                   registered set/reset commands to the magnetron latch
//   mag_on                 internal copy of the magnetron latch state
//   master drives the buttons/door/timer; slave (the control core) drives S/R/mag_on
interface magnetron_logic_if;
   logic start_;
   logic stop_;
   logic clear_;
   logic door_closed;
   logic timer_done;
   logic S;
   logic R;
   logic mag_on;
   modport master (output start_, stop_, clear_, door_closed, timer_done, input S, R, mag_on);
   modport slave (input start_, stop_, clear_, door_closed, timer_done, output S, R, mag_on);
endinterface

// File: rtl/magnetron_logic.sv
// magnetron_logic: turns buttons, door switch and timer expiry into S/R commands for the magnetron latch
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    magnetron_logic_if.slave: start_/stop_/clear_/door_closed/timer_done in, S/R/mag_on out
module magnetron_logic #(
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic reset,
   magnetron_logic_if.slave bus
);
   // Bit order {timer_done, door_closed, clear_, stop_, start_}; idle levels keep the magnetron off
   localparam logic [4:0] SAFE = 5'b00111;
   logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
   logic [4:0] sync_s;
   logic start_s, stop_s, clear_s, door_closed_s, timer_done_s;
   logic r_req, s_req;
   logic s_q, s_d, r_q, r_d, mag_on_q, mag_on_d;
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], {bus.timer_done, bus.door_closed, bus.clear_, bus.stop_, bus.start_}};
      sync_s = sync_q[SYNC_STAGES-1];
      {timer_done_s, door_closed_s, clear_s, stop_s, start_s} = sync_s;
      // Any reset condition masks start, so S and R can never be high together
      r_req = ~stop_s | ~clear_s | ~door_closed_s | timer_done_s;
      s_req = ~start_s & door_closed_s & ~timer_done_s & ~r_req;
      s_d = s_req;
      r_d = r_req;
      mag_on_d = r_q ? 1'b0 : s_q ? 1'b1 : mag_on_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{SAFE}};
         s_q <= 1'b0;
         r_q <= 1'b1;
         mag_on_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         s_q <= s_d;
         r_q <= r_d;
         mag_on_q <= mag_on_d;
      end
   end
   assign bus.S = s_q;
   assign bus.R = r_q;
   assign bus.mag_on = mag_on_q;
endmodule

// File: tb/tb_magnetron_logic.sv
// tb_magnetron_logic: directed checks of the magnetron control core with SYNC_STAGES=2
module tb_magnetron_logic;
   logic clk;
   logic reset;
   int errors;
   int checks;
   int sr_both;
   magnetron_logic_if bus ();
   magnetron_logic #(.SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.S & bus.R) sr_both++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic run_start();
      bus.start_ = 1'b0;
      tick(1);
      bus.start_ = 1'b1;
      tick(2);
      chk("run_s_high", bus.S, 1);
      chk("run_r_low", bus.R, 0);
      tick(1);
      chk("run_s_drop", bus.S, 0);
      chk("run_mag_on", bus.mag_on, 1);
   endtask
   initial begin
      errors = 0;
      checks = 0;
      sr_both = 0;
      reset = 1'b1;
      bus.start_ = 1'b1;
      bus.stop_ = 1'b1;
      bus.clear_ = 1'b1;
      bus.door_closed = 1'b0;
      bus.timer_done = 1'b0;
      tick(2);
      chk("rst_s", bus.S, 0);
      chk("rst_r", bus.R, 1);
      chk("rst_mag", bus.mag_on, 0);
      reset = 1'b0;
      // 1: start with door open
      bus.start_ = 1'b0;
      tick(1);
      bus.start_ = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("open_s", bus.S, 0);
         chk("open_r", bus.R, 1);
         chk("open_mag", bus.mag_on, 0);
      end
      // 2: normal start, then clear
      bus.door_closed = 1'b1;
      tick(4);
      chk("closed_idle_r", bus.R, 0);
      chk("closed_idle_s", bus.S, 0);
      run_start();
      tick(1);
      chk("latched_mag", bus.mag_on, 1);
      chk("latched_r", bus.R, 0);
      bus.clear_ = 1'b0;
      tick(1);
      bus.clear_ = 1'b1;
      tick(2);
      chk("clear_r", bus.R, 1);
      chk("clear_s", bus.S, 0);
      tick(1);
      chk("clear_r_one_cycle", bus.R, 0);
      chk("clear_mag", bus.mag_on, 0);
      // 3: timer expiry, start ignored while expired
      run_start();
      bus.timer_done = 1'b1;
      tick(3);
      chk("timer_r", bus.R, 1);
      tick(1);
      chk("timer_mag", bus.mag_on, 0);
      bus.start_ = 1'b0;
      tick(1);
      bus.start_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("timer_start_s", bus.S, 0);
      end
      bus.timer_done = 1'b0;
      tick(4);
      chk("timer_clr_r", bus.R, 0);
      chk("timer_clr_mag", bus.mag_on, 0);
      // 4: door opened mid-cook, closing does not restart
      run_start();
      bus.door_closed = 1'b0;
      tick(1);
      bus.door_closed = 1'b1;
      tick(2);
      chk("door_r", bus.R, 1);
      tick(1);
      chk("door_mag", bus.mag_on, 0);
      tick(3);
      chk("door_no_restart", bus.mag_on, 0);
      chk("door_no_restart_s", bus.S, 0);
      run_start();
      bus.timer_done = 1'b1;
      tick(4);
      chk("door_timer_mag", bus.mag_on, 0);
      bus.timer_done = 1'b0;
      tick(4);
      // 5: start and stop together
      bus.start_ = 1'b0;
      bus.stop_ = 1'b0;
      tick(1);
      bus.start_ = 1'b1;
      bus.stop_ = 1'b1;
      tick(2);
      chk("both_s", bus.S, 0);
      chk("both_r", bus.R, 1);
      tick(1);
      chk("both_mag", bus.mag_on, 0);
      tick(3);
      // no edge detection: held start keeps S high
      bus.start_ = 1'b0;
      tick(2);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("hold_s", bus.S, 1);
      end
      bus.start_ = 1'b1;
      tick(4);
      chk("hold_mag", bus.mag_on, 1);
      chk("hold_s_off", bus.S, 0);
      // 6: async reset mid-cook
      #3;
      reset = 1'b1;
      #1;
      chk("areset_s", bus.S, 0);
      chk("areset_r", bus.R, 1);
      chk("areset_mag", bus.mag_on, 0);
      tick(2);
      reset = 1'b0;
      chk("post_rst_r", bus.R, 1);
      tick(3);
      chk("post_rst_r_low", bus.R, 0);
      chk("post_rst_mag", bus.mag_on, 0);
      run_start();
      chk("s_and_r_never", sr_both, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
